// File: rtl/ysyx_25010008_arch_pkg.sv
// ysyx_25010008_arch_pkg
//   Shared definitions for the architectural-state block: implemented CSR
//   addresses, mstatus field positions, the mstatus reset value, and helper
//   functions for the trap/mret mstatus updates and the CSR write rules.
//   No ports (package).
package ysyx_25010008_arch_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;
    localparam logic [1:0]  PRIV_M      = 2'b11;

    // Trap entry: stack MIE into MPIE, mask interrupts, previous mode = M.
    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] ms);
        logic [31:0] r;
        r                               = ms;
        r[MSTATUS_MPIE]                 = ms[MSTATUS_MIE];
        r[MSTATUS_MIE]                  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
        return r;
    endfunction

    // Trap return: restore MIE from MPIE, set MPIE, previous mode stays M.
    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] ms);
        logic [31:0] r;
        r                               = ms;
        r[MSTATUS_MIE]                  = ms[MSTATUS_MPIE];
        r[MSTATUS_MPIE]                 = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
        return r;
    endfunction

    // Software-writable CSRs; the counters are read-only here.
    function automatic logic csr_writable(input logic [11:0] addr);
        logic w;
        case (addr)
            CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE: w = 1'b1;
            default:                                                 w = 1'b0;
        endcase
        return w;
    endfunction

    // Value actually stored by a CSR write: mepc is kept 4-byte aligned.
    function automatic logic [31:0] csr_wr_value(input logic [11:0] addr, input logic [31:0] data);
        logic [31:0] v;
        if (addr == CSR_MEPC) begin
            v = {data[31:2], 2'b00};
        end else begin
            v = data;
        end
        return v;
    endfunction

endpackage

// File: rtl/ysyx_25010008_arch_state_if.sv
// ysyx_25010008_arch_state_if
//   Bus between the core pipeline (master: decode read indices, write-back,
//   trap/mret control) and the architectural-state block (slave).
//   Signals: rs_idx/rs_data (GPR read ports), wb_valid/gpr_wen/rd_idx/rd_data
//   (GPR write), csr_raddr/csr_rdata/csr_illegal (CSR read), csr_wen/csr_waddr/
//   csr_wdata (CSR write), trap_valid/trap_pc/trap_cause, mret_valid,
//   trap_vector/mepc_out (redirect targets).
interface ysyx_25010008_arch_state_if #(
    parameter int XLEN     = 32,
    parameter int NR_RPORT = 2
);
    logic [NR_RPORT*5-1:0]    rs_idx;
    logic [NR_RPORT*XLEN-1:0] rs_data;
    logic                     wb_valid;
    logic                     gpr_wen;
    logic [4:0]               rd_idx;
    logic [XLEN-1:0]          rd_data;
    logic [11:0]              csr_raddr;
    logic [XLEN-1:0]          csr_rdata;
    logic                     csr_illegal;
    logic                     csr_wen;
    logic [11:0]              csr_waddr;
    logic [XLEN-1:0]          csr_wdata;
    logic                     trap_valid;
    logic [XLEN-1:0]          trap_pc;
    logic [XLEN-1:0]          trap_cause;
    logic                     mret_valid;
    logic [XLEN-1:0]          trap_vector;
    logic [XLEN-1:0]          mepc_out;

    modport master (
        output rs_idx, wb_valid, gpr_wen, rd_idx, rd_data, csr_raddr,
               csr_wen, csr_waddr, csr_wdata, trap_valid, trap_pc, trap_cause, mret_valid,
        input  rs_data, csr_rdata, csr_illegal, trap_vector, mepc_out
    );

    modport slave (
        input  rs_idx, wb_valid, gpr_wen, rd_idx, rd_data, csr_raddr,
               csr_wen, csr_waddr, csr_wdata, trap_valid, trap_pc, trap_cause, mret_valid,
        output rs_data, csr_rdata, csr_illegal, trap_vector, mepc_out
    );
endinterface

// File: rtl/ysyx_25010008_counter64.sv
// ysyx_25010008_counter64
//   64-bit free-running event counter built from two 32-bit halves, the low
//   half's carry feeding the high half; wraps to zero.
//   Ports: clk, rst (sync, active-high), en (count this cycle), count (value).
module ysyx_25010008_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [63:0] count
);
    logic [63:0] cnt_q;
    logic [63:0] cnt_d;
    logic [31:0] lo_s;
    logic        carry_s;

    // Next count: increment low half, ripple its carry into the high half.
    always_comb begin
        {carry_s, lo_s} = {1'b0, cnt_q[31:0]} + 33'd1;
        if (en) begin
            cnt_d = {cnt_q[63:32] + {31'd0, carry_s}, lo_s};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 64'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/ysyx_25010008_arch_state.sv
// ysyx_25010008_arch_state
//   Architectural state of the NPC core: GPR file (x0 hard-wired to zero) and
//   the M-mode CSR bank (mstatus, mtvec, mscratch, mepc, mcause, mcycle[h],
//   minstret[h]) with atomic trap entry and mret.
//   Ports: clk, rst (sync, active-high), bus (ysyx_25010008_arch_state_if.slave).
//   All read outputs are combinational on current state.
//   Build option: ARCH_STATE_BYPASS_EN -- same-cycle write-to-read forwarding
//   for GPR and CSR reads; without it writes become visible the next cycle.
module ysyx_25010008_arch_state
    import ysyx_25010008_arch_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NR_GPR   = 16,
    parameter int NR_RPORT = 2
) (
    input logic                      clk,
    input logic                      rst,
    ysyx_25010008_arch_state_if.slave bus
);
    localparam int IW = $clog2(NR_GPR);

    logic [XLEN-1:0] gpr_q [NR_GPR];
    logic [XLEN-1:0] gpr_d [NR_GPR];

    logic [XLEN-1:0] mstatus_q, mstatus_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;

    logic [63:0]              mcycle_s;
    logic [63:0]              minstret_s;
    logic [IW-1:0]            rd_sel_s;
    logic                     gpr_we_s;
    logic                     csr_we_s;
    logic                     minstret_en_s;
    logic [XLEN-1:0]          csr_wv_s;
    logic [XLEN-1:0]          csr_reg_s;
    logic [XLEN-1:0]          csr_rdata_s;
    logic                     csr_illegal_s;
    logic [NR_RPORT*XLEN-1:0] rs_data_s;
    logic                     unused_s;

    // Only the low IW index bits select a register; the rest are don't-care.
    assign rd_sel_s      = bus.rd_idx[IW-1:0];
    assign unused_s      = ^{bus.rs_idx, bus.rd_idx};
    // A trap squashes the retiring instruction's GPR and CSR side effects.
    assign gpr_we_s      = bus.wb_valid & bus.gpr_wen & ~bus.trap_valid & (rd_sel_s != {IW{1'b0}});
    assign csr_we_s      = bus.wb_valid & bus.csr_wen & ~bus.trap_valid;
    assign minstret_en_s = bus.wb_valid & ~bus.trap_valid;
    assign csr_wv_s      = csr_wr_value(bus.csr_waddr, bus.csr_wdata);

    // GPR next state: single write port, x0 never written.
    always_comb begin
        for (int i = 0; i < NR_GPR; i++) begin
            gpr_d[i] = gpr_q[i];
        end
        if (gpr_we_s) begin
            gpr_d[rd_sel_s] = bus.rd_data;
        end else begin
            gpr_d[rd_sel_s] = gpr_q[rd_sel_s];
        end
    end

    // GPR register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR_GPR; i++) begin
                gpr_q[i] <= {XLEN{1'b0}};
            end
        end else begin
            for (int i = 0; i < NR_GPR; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
        end
    end

    for (genvar p = 0; p < NR_RPORT; p++) begin : g_rport
        logic [IW-1:0]   sel_s;
        logic [XLEN-1:0] val_s;

        assign sel_s = bus.rs_idx[5*p +: IW];

        // Read mux for one port; x0 always reads zero.
        always_comb begin
            if (sel_s == {IW{1'b0}}) begin
                val_s = {XLEN{1'b0}};
`ifdef ARCH_STATE_BYPASS_EN
            end else if (gpr_we_s && (sel_s == rd_sel_s)) begin
                val_s = bus.rd_data;
`endif
            end else begin
                val_s = gpr_q[sel_s];
            end
        end

        assign rs_data_s[XLEN*p +: XLEN] = val_s;
    end

    // CSR next state: trap beats mret beats software writes.
    always_comb begin
        mstatus_d  = mstatus_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        if (bus.trap_valid) begin
            mepc_d    = {bus.trap_pc[XLEN-1:2], 2'b00};
            mcause_d  = bus.trap_cause;
            mstatus_d = mstatus_on_trap(mstatus_q);
        end else begin
            // mret owns mstatus this cycle; other CSR writes still land.
            if (bus.mret_valid) begin
                mstatus_d = mstatus_on_mret(mstatus_q);
            end else if (csr_we_s && (bus.csr_waddr == CSR_MSTATUS)) begin
                mstatus_d = csr_wv_s;
            end else begin
                mstatus_d = mstatus_q;
            end
            if (csr_we_s) begin
                case (bus.csr_waddr)
                    CSR_MTVEC:    mtvec_d    = csr_wv_s;
                    CSR_MSCRATCH: mscratch_d = csr_wv_s;
                    CSR_MEPC:     mepc_d     = csr_wv_s;
                    CSR_MCAUSE:   mcause_d   = csr_wv_s;
                    // mstatus handled above; counters and unknown addresses drop the write
                    default:      mtvec_d    = mtvec_q;
                endcase
            end else begin
                mtvec_d = mtvec_q;
            end
        end
    end

    // CSR registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_q  <= MSTATUS_RST;
            mtvec_q    <= {XLEN{1'b0}};
            mscratch_q <= {XLEN{1'b0}};
            mepc_q     <= {XLEN{1'b0}};
            mcause_q   <= {XLEN{1'b0}};
        end else begin
            mstatus_q  <= mstatus_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

    ysyx_25010008_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .count (mcycle_s)
    );

    ysyx_25010008_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .en    (minstret_en_s),
        .count (minstret_s)
    );

    // CSR read decode; unimplemented addresses read zero and flag illegal.
    always_comb begin
        csr_reg_s     = {XLEN{1'b0}};
        csr_illegal_s = 1'b0;
        case (bus.csr_raddr)
            CSR_MSTATUS:   csr_reg_s = mstatus_q;
            CSR_MTVEC:     csr_reg_s = mtvec_q;
            CSR_MSCRATCH:  csr_reg_s = mscratch_q;
            CSR_MEPC:      csr_reg_s = mepc_q;
            CSR_MCAUSE:    csr_reg_s = mcause_q;
            CSR_MCYCLE:    csr_reg_s = mcycle_s[31:0];
            CSR_MCYCLEH:   csr_reg_s = mcycle_s[63:32];
            CSR_MINSTRET:  csr_reg_s = minstret_s[31:0];
            CSR_MINSTRETH: csr_reg_s = minstret_s[63:32];
            default: begin
                csr_reg_s     = {XLEN{1'b0}};
                csr_illegal_s = 1'b1;
            end
        endcase
    end

    // CSR read data, optionally forwarding a same-address write (the stored form).
    always_comb begin
`ifdef ARCH_STATE_BYPASS_EN
        if (csr_we_s && !bus.mret_valid && (bus.csr_waddr == bus.csr_raddr) &&
            csr_writable(bus.csr_waddr)) begin
            csr_rdata_s = csr_wv_s;
        end else begin
            csr_rdata_s = csr_reg_s;
        end
`else
        csr_rdata_s = csr_reg_s;
`endif
    end

    assign bus.rs_data     = rs_data_s;
    assign bus.csr_rdata   = csr_rdata_s;
    assign bus.csr_illegal = csr_illegal_s;
    assign bus.trap_vector = {mtvec_q[XLEN-1:2], 2'b00};
    assign bus.mepc_out    = mepc_q;

endmodule

// File: tb/tb_ysyx_25010008_arch_state.sv
module tb_ysyx_25010008_arch_state;
    import ysyx_25010008_arch_pkg::*;

    localparam int XLEN     = 32;
    localparam int NR_GPR   = 16;
    localparam int NR_RPORT = 2;

    logic clk = 1'b0;
    logic rst;

    ysyx_25010008_arch_state_if #(.XLEN(XLEN), .NR_RPORT(NR_RPORT)) bus ();

    ysyx_25010008_arch_state #(.XLEN(XLEN), .NR_GPR(NR_GPR), .NR_RPORT(NR_RPORT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #50 clk = ~clk;

    int          n_vec  = 0;
    int          n_miss = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];
    logic [63:0] cyc_m;
    logic [63:0] inst_m;

    // Reference counters: cycles since reset, and non-trapped retirements.
    always @(posedge clk) begin
        if (rst) begin
            cyc_m  <= 64'd0;
            inst_m <= 64'd0;
        end else begin
            cyc_m <= cyc_m + 64'd1;
            if (bus.wb_valid && !bus.trap_valid) inst_m <= inst_m + 64'd1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic expect_val(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic compare(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_miss++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            tag = tag_q.pop_front();
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                n_miss++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
            end
        end
    endtask

    task automatic chk_gpr(input int port, input logic [4:0] idx, input logic [31:0] exp, input string tag);
        bus.rs_idx[port*5 +: 5] = idx;
        expect_val(tag, exp);
        #1;
        compare(bus.rs_data[port*XLEN +: XLEN]);
    endtask

    task automatic chk_csr(input logic [11:0] addr, input logic [31:0] exp, input string tag);
        bus.csr_raddr = addr;
        expect_val(tag, exp);
        #1;
        compare(bus.csr_rdata);
    endtask

    task automatic chk_ill(input logic [11:0] addr, input logic exp, input string tag);
        bus.csr_raddr = addr;
        expect_val(tag, {31'd0, exp});
        #1;
        compare({31'd0, bus.csr_illegal});
    endtask

    task automatic idle();
        bus.wb_valid   = 1'b0;
        bus.gpr_wen    = 1'b0;
        bus.rd_idx     = 5'd0;
        bus.rd_data    = 32'd0;
        bus.csr_wen    = 1'b0;
        bus.csr_waddr  = 12'h000;
        bus.csr_wdata  = 32'd0;
        bus.trap_valid = 1'b0;
        bus.trap_pc    = 32'd0;
        bus.trap_cause = 32'd0;
        bus.mret_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic gpr_write(input logic [4:0] idx, input logic [31:0] data);
        bus.wb_valid = 1'b1;
        bus.gpr_wen  = 1'b1;
        bus.rd_idx   = idx;
        bus.rd_data  = data;
        step();
        idle();
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        bus.wb_valid  = 1'b1;
        bus.csr_wen   = 1'b1;
        bus.csr_waddr = addr;
        bus.csr_wdata = data;
        step();
        idle();
    endtask

    initial begin
        idle();
        bus.rs_idx    = 10'd0;
        bus.csr_raddr = 12'h000;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk_csr(CSR_MCYCLE, 32'd0, "mcycle_first_cycle");
        for (int i = 1; i < 16; i++) begin
            logic [4:0] idx;
            idx = i[4:0];
            chk_gpr(i % 2, idx, 32'd0, $sformatf("gpr_reset_x%0d", i));
        end
        chk_csr(CSR_MSTATUS, 32'h0000_1800, "mstatus_reset");
        chk_ill(CSR_MSTATUS, 1'b0, "mstatus_legal");
        chk_csr(CSR_MTVEC, 32'd0, "mtvec_reset");
        chk_csr(12'h7C0, 32'd0, "unknown_csr_rdata");
        chk_ill(12'h7C0, 1'b1, "unknown_csr_illegal");
        step();
        chk_csr(CSR_MCYCLE, 32'd1, "mcycle_second_cycle");

        // GPR writes, x0 and index aliasing
        gpr_write(5'd0, 32'h0000_DEAD);
        chk_gpr(0, 5'd0, 32'd0, "x0_write_dropped");
        gpr_write(5'd5, 32'h0000_1234);
        chk_gpr(1, 5'd5, 32'h0000_1234, "x5_write");
        gpr_write(5'd21, 32'h0000_5A5A);
        chk_gpr(1, 5'd5, 32'h0000_5A5A, "rd21_aliases_x5");
        chk_gpr(0, 5'd21, 32'h0000_5A5A, "rs21_aliases_x5");

        // CSR writes, trap and mret
        csr_write(CSR_MTVEC, 32'h8000_0007);
        chk_csr(CSR_MTVEC, 32'h8000_0007, "mtvec_write");
        expect_val("trap_vector", 32'h8000_0004);
        #1;
        compare(bus.trap_vector);
        csr_write(CSR_MEPC, 32'h0000_1237);
        chk_csr(CSR_MEPC, 32'h0000_1234, "mepc_write_aligned");
        csr_write(CSR_MSTATUS, 32'h0000_1808);
        chk_csr(CSR_MSTATUS, 32'h0000_1808, "mstatus_write");
        bus.trap_valid = 1'b1;
        bus.trap_pc    = 32'h8000_0103;
        bus.trap_cause = 32'd11;
        step();
        idle();
        chk_csr(CSR_MEPC, 32'h8000_0100, "trap_mepc");
        expect_val("mepc_out", 32'h8000_0100);
        #1;
        compare(bus.mepc_out);
        chk_csr(CSR_MCAUSE, 32'd11, "trap_mcause");
        chk_csr(CSR_MSTATUS, 32'h0000_1880, "trap_mstatus");
        bus.mret_valid = 1'b1;
        step();
        idle();
        chk_csr(CSR_MSTATUS, 32'h0000_1888, "mret_mstatus");
        bus.mret_valid = 1'b1;
        bus.wb_valid   = 1'b1;
        bus.csr_wen    = 1'b1;
        bus.csr_waddr  = CSR_MSTATUS;
        bus.csr_wdata  = 32'd0;
        step();
        idle();
        chk_csr(CSR_MSTATUS, 32'h0000_1888, "mret_beats_mstatus_write");
        bus.mret_valid = 1'b1;
        bus.wb_valid   = 1'b1;
        bus.csr_wen    = 1'b1;
        bus.csr_waddr  = CSR_MSCRATCH;
        bus.csr_wdata  = 32'h0000_0077;
        step();
        idle();
        chk_csr(CSR_MSCRATCH, 32'h0000_0077, "mret_keeps_other_csr_write");

        // Trap squashes same-cycle CSR/GPR writes and beats mret
        bus.wb_valid   = 1'b1;
        bus.gpr_wen    = 1'b1;
        bus.rd_idx     = 5'd3;
        bus.rd_data    = 32'h0000_0099;
        bus.csr_wen    = 1'b1;
        bus.csr_waddr  = CSR_MTVEC;
        bus.csr_wdata  = 32'h0000_0040;
        bus.trap_valid = 1'b1;
        bus.trap_pc    = 32'h0000_0100;
        bus.trap_cause = 32'd2;
        bus.mret_valid = 1'b1;
        step();
        idle();
        chk_csr(CSR_MTVEC, 32'h8000_0007, "trap_squashes_csr_write");
        chk_gpr(0, 5'd3, 32'd0, "trap_squashes_gpr_write");
        chk_csr(CSR_MSTATUS, 32'h0000_1880, "trap_beats_mret");
        chk_csr(CSR_MEPC, 32'h0000_0100, "trap2_mepc");
        chk_csr(CSR_MCAUSE, 32'd2, "trap2_mcause");

        // Counters
        chk_csr(CSR_MINSTRET, inst_m[31:0], "minstret_count");
        chk_csr(CSR_MINSTRETH, 32'd0, "minstreth_zero");
        chk_csr(CSR_MCYCLE, cyc_m[31:0], "mcycle_count");
        force dut.u_minstret.cnt_q = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.u_minstret.cnt_q;
        chk_csr(CSR_MINSTRET, 32'hFFFF_FFFF, "minstret_preload");
        bus.wb_valid = 1'b1;
        step();
        idle();
        chk_csr(CSR_MINSTRET, 32'd0, "minstret_low_wrap");
        chk_csr(CSR_MINSTRETH, 32'd1, "minstreth_carry");
        csr_write(CSR_MCYCLEH, 32'hFFFF_FFFF);
        chk_csr(CSR_MCYCLEH, 32'd0, "mcycleh_write_ignored");
        chk_csr(CSR_MINSTRET, 32'd1, "minstret_after_carry");
        csr_write(CSR_MINSTRET, 32'h0000_1234);
        chk_csr(CSR_MINSTRET, 32'd2, "minstret_write_ignored");

        // Same-cycle read of a register being written
        gpr_write(5'd7, 32'h0000_0011);
        bus.wb_valid  = 1'b1;
        bus.gpr_wen   = 1'b1;
        bus.rd_idx    = 5'd7;
        bus.rd_data   = 32'h0000_0055;
        bus.csr_wen   = 1'b1;
        bus.csr_waddr = CSR_MSCRATCH;
        bus.csr_wdata = 32'h0000_0ABC;
`ifdef ARCH_STATE_BYPASS_EN
        chk_gpr(0, 5'd7, 32'h0000_0055, "x7_same_cycle_bypass");
        chk_csr(CSR_MSCRATCH, 32'h0000_0ABC, "mscratch_same_cycle_bypass");
`else
        chk_gpr(0, 5'd7, 32'h0000_0011, "x7_same_cycle_old");
        chk_csr(CSR_MSCRATCH, 32'h0000_0077, "mscratch_same_cycle_old");
`endif
        step();
        idle();
        chk_gpr(0, 5'd7, 32'h0000_0055, "x7_next_cycle");
        chk_csr(CSR_MSCRATCH, 32'h0000_0ABC, "mscratch_next_cycle");

        // Reset mid-operation overrides a pending write
        rst          = 1'b1;
        bus.wb_valid = 1'b1;
        bus.gpr_wen  = 1'b1;
        bus.rd_idx   = 5'd9;
        bus.rd_data  = 32'h0000_0033;
        step();
        idle();
        rst = 1'b0;
        chk_gpr(0, 5'd9, 32'd0, "rst_blocks_gpr_write");
        chk_gpr(1, 5'd5, 32'd0, "rst_clears_x5");
        chk_csr(CSR_MSTATUS, 32'h0000_1800, "rst_mstatus");
        chk_csr(CSR_MSCRATCH, 32'd0, "rst_mscratch");
        chk_csr(CSR_MEPC, 32'd0, "rst_mepc");
        chk_csr(CSR_MINSTRETH, 32'd0, "rst_minstreth");
        chk_csr(CSR_MCYCLE, 32'd0, "rst_mcycle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
